// File: rtl/ufi_write_buffer.sv
// FWFT write buffer in front of the RamBlock UFI write port: circular {adrs,data} array plus one output register.
// Optional feature: define UFI_WBUF_OVF_CNT_EN to add the saturating dropped-push counter oOvfCnt.
module ufi_write_buffer #(
  parameter int pDqWidth    = 16,
  parameter int pAdrsWidth  = 16,
  parameter int pDepthWidth = 4
) (
  input  logic                    iSCLK,
  input  logic                    iSRST,
  input  logic [pDqWidth-1:0]     iWd,
  input  logic [pAdrsWidth-1:0]   iAdrs,
  input  logic                    iWe,
  input  logic                    iFlush,
  output logic                    oFull,
  output logic                    oEmpty,
  output logic [pDepthWidth:0]    oCount,
  output logic                    oOvf,
  output logic [pDqWidth-1:0]     oSUfiWd,
  output logic [pAdrsWidth-1:0]   oSUfiAdrs,
  output logic                    oSUfiWEd,
`ifdef UFI_WBUF_OVF_CNT_EN
  output logic [15:0]             oOvfCnt,
`endif
  input  logic                    iSUfiRdy
);

  localparam int ENTRY_W = pDqWidth + pAdrsWidth;
  localparam int DEPTH   = 1 << pDepthWidth;
  localparam logic [pDepthWidth:0] FULL_CNT = {1'b1, {pDepthWidth{1'b0}}};

  logic [ENTRY_W-1:0]     mem [DEPTH];
  logic [pDepthWidth-1:0] wr_ptr;
  logic [pDepthWidth-1:0] rd_ptr;
  logic [pDepthWidth:0]   cnt_q;
  logic [pDepthWidth:0]   mem_cnt;
  logic                   out_vld;
  logic [pDqWidth-1:0]    out_wd;
  logic [pAdrsWidth-1:0]  out_adrs;
  logic                   ovf_q;
  logic                   push_ok;
  logic                   pop;
  logic                   load;

  // Full is decided from the registered count only, so a same-edge pop never frees room for a push.
  assign oFull   = (cnt_q == FULL_CNT);
  assign oEmpty  = (cnt_q == '0);
  assign push_ok = iWe && !oFull;
  assign pop     = out_vld && iSUfiRdy;
  assign mem_cnt = cnt_q - {{pDepthWidth{1'b0}}, out_vld};
  assign load    = (!out_vld || pop) && (mem_cnt != '0);

  always_ff @(posedge iSCLK or posedge iSRST) begin
    if (iSRST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt_q    <= '0;
      out_vld  <= 1'b0;
      out_wd   <= '0;
      out_adrs <= '0;
      ovf_q    <= 1'b0;
    end else if (iFlush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      out_vld <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= iWe && oFull;
      cnt_q <= cnt_q + {{pDepthWidth{1'b0}}, push_ok} - {{pDepthWidth{1'b0}}, pop};
      if (push_ok)
        wr_ptr <= wr_ptr + pDepthWidth'(1);
      if (load) begin
        rd_ptr   <= rd_ptr + pDepthWidth'(1);
        out_vld  <= 1'b1;
        out_adrs <= mem[rd_ptr][ENTRY_W-1:pDqWidth];
        out_wd   <= mem[rd_ptr][pDqWidth-1:0];
      end else if (pop) begin
        out_vld <= 1'b0;
      end
    end
  end

  // Storage array carries no reset; its contents are only read behind a valid count.
  always_ff @(posedge iSCLK) begin
    if (push_ok && !iFlush)
      mem[wr_ptr] <= {iAdrs, iWd};
  end

`ifdef UFI_WBUF_OVF_CNT_EN
  logic [15:0] ovf_cnt;

  always_ff @(posedge iSCLK or posedge iSRST) begin
    if (iSRST)
      ovf_cnt <= '0;
    else if (iFlush)
      ovf_cnt <= '0;
    else if (iWe && oFull && (ovf_cnt != 16'hFFFF))
      ovf_cnt <= ovf_cnt + 16'd1;
  end

  assign oOvfCnt = ovf_cnt;
`endif

  assign oCount    = cnt_q;
  assign oOvf      = ovf_q;
  assign oSUfiWd   = out_wd;
  assign oSUfiAdrs = out_adrs;
  assign oSUfiWEd  = out_vld;

endmodule

// File: tb/tb_ufi_write_buffer.sv
// Directed bench for ufi_write_buffer: reset, single word, fill/stall, backpressure, simultaneous push/pop, flush.
module tb_ufi_write_buffer;

  logic        clk;
  logic        rst;
  logic [15:0] wd;
  logic [15:0] adrs;
  logic        we;
  logic        flush;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic        ovf;
  logic [15:0] ufi_wd;
  logic [15:0] ufi_adrs;
  logic        ufi_wed;
  logic        rdy;
`ifdef UFI_WBUF_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  ufi_write_buffer #(.pDqWidth(16), .pAdrsWidth(16), .pDepthWidth(4)) dut (
    .iSCLK     (clk),
    .iSRST     (rst),
    .iWd       (wd),
    .iAdrs     (adrs),
    .iWe       (we),
    .iFlush    (flush),
    .oFull     (full),
    .oEmpty    (empty),
    .oCount    (count),
    .oOvf      (ovf),
    .oSUfiWd   (ufi_wd),
    .oSUfiAdrs (ufi_adrs),
    .oSUfiWEd  (ufi_wed),
`ifdef UFI_WBUF_OVF_CNT_EN
    .oOvfCnt   (ovf_cnt),
`endif
    .iSUfiRdy  (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [15:0] a);
    we = 1'b1; wd = d; adrs = a;
    tick();
    we = 1'b0;
  endtask

  initial begin
    int idx;
    rst = 1'b1; we = 1'b0; flush = 1'b0; rdy = 1'b1; wd = '0; adrs = '0;

    // 1 reset
    repeat (5) tick();
    chk("rst_full",  full,     0);
    chk("rst_empty", empty,    1);
    chk("rst_count", count,    0);
    chk("rst_ovf",   ovf,      0);
    chk("rst_wd",    ufi_wd,   0);
    chk("rst_adrs",  ufi_adrs, 0);
    chk("rst_wed",   ufi_wed,  0);
    rst = 1'b0;
    tick();

    // 2 single word
    push(16'hA5A5, 16'h0010);
    chk("s_wed_n",   ufi_wed, 0);
    chk("s_count_n", count,   1);
    chk("s_empty_n", empty,   0);
    tick();
    chk("s_wed_n1",  ufi_wed,  1);
    chk("s_wd_n1",   ufi_wd,   16'hA5A5);
    chk("s_adrs_n1", ufi_adrs, 16'h0010);
    tick();
    chk("s_wed_n2",   ufi_wed, 0);
    chk("s_empty_n2", empty,   1);

    // 3 fill while stalled, overflow, drain in order (pointers wrap)
    rdy = 1'b0;
    for (int i = 0; i < 16; i++) push(16'h1000 + 16'(i), 16'(i));
    chk("f_full",  full,   1);
    chk("f_count", count,  16);
    chk("f_wed",   ufi_wed, 1);
    chk("f_wd0",   ufi_wd, 16'h1000);
    chk("f_ovf_pre", ovf,  0);
    push(16'hDEAD, 16'hBEEF);
    chk("f_ovf",     ovf,   1);
    chk("f_count17", count, 16);
    chk("f_wd_hold", ufi_wd, 16'h1000);
    tick();
    chk("f_ovf_pulse", ovf, 0);
    rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("d_wed",  ufi_wed,  1);
      chk("d_wd",   ufi_wd,   16'h1000 + 16'(i));
      chk("d_adrs", ufi_adrs, 16'(i));
      tick();
    end
    chk("d_wed_end", ufi_wed, 0);
    chk("d_empty",   empty,   1);

    // 4 backpressure: ready toggles every cycle
    rdy = 1'b0;
    for (int i = 0; i < 8; i++) push(16'h2000 + 16'(i), 16'h0200 + 16'(i));
    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      rdy = c[0];
      chk("b_wed",  ufi_wed,  1);
      chk("b_wd",   ufi_wd,   16'h2000 + 16'(idx));
      chk("b_adrs", ufi_adrs, 16'h0200 + 16'(idx));
      tick();
      if (rdy) idx++;
    end
    chk("b_all_out", idx, 8);
    chk("b_empty", empty, 1);
    chk("b_wed_end", ufi_wed, 0);

    // 5 simultaneous push and pop
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) push(16'h3000 + 16'(i), 16'(i));
    chk("p_count5", count, 5);
    rdy = 1'b1;
    push(16'h3005, 16'h0005);
    chk("p_count_same", count, 5);
    chk("p_wd_next",    ufi_wd, 16'h3001);
    rdy = 1'b0;
    for (int i = 6; i < 17; i++) push(16'h3000 + 16'(i), 16'(i));
    chk("p_full", full, 1);
    chk("p_count16", count, 16);
    rdy = 1'b1;
    push(16'hBAD0, 16'hBAD0);
    chk("p_ovf",     ovf,    1);
    chk("p_count15", count,  15);
    chk("p_notfull", full,   0);
    chk("p_wd_2",    ufi_wd, 16'h3002);
`ifdef UFI_WBUF_OVF_CNT_EN
    chk("p_ovfcnt", ovf_cnt, 2);
`endif
    repeat (20) tick();
    chk("p_drained", empty, 1);

    // 6 flush with concurrent push
    rdy = 1'b0;
    for (int i = 0; i < 9; i++) push(16'h4000 + 16'(i), 16'(i));
    chk("l_count9", count, 9);
    flush = 1'b1;
    push(16'h4009, 16'h0009);
    flush = 1'b0;
    chk("l_count", count,   0);
    chk("l_wed",   ufi_wed, 0);
    chk("l_ovf",   ovf,     0);
    chk("l_empty", empty,   1);
`ifdef UFI_WBUF_OVF_CNT_EN
    chk("l_ovfcnt", ovf_cnt, 0);
`endif
    rdy = 1'b1;
    tick();
    chk("l_count_after", count,   0);
    chk("l_wed_after",   ufi_wed, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
